// File: rtl/pacman_obj_fetch.sv
// pacman_obj_fetch: copies the object attribute table from shared RAM into a
// local shadow buffer during each vertical blanking interval, using only the
// cycles in which the arbiter grants access (ce). The display side reads the
// shadow through a registered port and never touches shared RAM.
// Optional feature: define OBJFETCH_DBUF_EN for a double-buffered shadow
// (fetch fills the hidden bank, banks swap when a full table has arrived).
module pacman_obj_fetch #(
    parameter logic [9:0] BASE_ADDR   = 10'h3F0,
    parameter int         COUNT       = 16,
    parameter int         VBLANK_LINE = 480
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce,
    input  logic [9:0] svpos,
    output logic [9:0] mem_addr,
    output logic       mem_rd,
    input  logic [7:0] mem_data,
    input  logic [5:0] buf_raddr,
    output logic [7:0] buf_rdata,
    output logic       frame_done,
    output logic       busy,
    output logic       overrun
);

    localparam logic [9:0] VB_LINE  = 10'(VBLANK_LINE);
    localparam logic [5:0] LAST_IDX = 6'(COUNT - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [5:0] issue_idx;
    logic       in_vb;
    logic       in_vb_q;
    logic       vb_rise;
    logic       clr_idx;
    logic       finish;
    logic       abort;
    logic       rd_q;
    logic [5:0] idx_q;

`ifdef OBJFETCH_DBUF_EN
    logic       rd_bank;
    logic [6:0] wr_ptr;
    logic [6:0] rd_ptr;
    logic [7:0] shadow [128];

    // Fetch fills the bank the display is not looking at.
    assign wr_ptr = {~rd_bank, idx_q};
    assign rd_ptr = {rd_bank, buf_raddr};

    // Display bank select flips only when a complete table has landed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_bank <= 1'b0;
        end else if (finish) begin
            rd_bank <= ~rd_bank;
        end
    end
`else
    logic [5:0] wr_ptr;
    logic [5:0] rd_ptr;
    logic [7:0] shadow [64];

    assign wr_ptr = idx_q;
    assign rd_ptr = buf_raddr;
`endif

    assign in_vb   = (svpos >= VB_LINE);
    assign vb_rise = in_vb && !in_vb_q;
    assign busy    = (state == FETCH) || (state == DRAIN);

    // Next-state and read-request decode.
    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path through the case leaves a signal unassigned (no latches).
        state_next = state;
        mem_rd     = 1'b0;
        mem_addr   = '0;
        clr_idx    = 1'b0;
        finish     = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (vb_rise) begin
                    clr_idx    = 1'b1;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (!in_vb) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end else if (ce) begin
                    mem_rd   = 1'b1;
                    mem_addr = BASE_ADDR + {4'b0000, issue_idx};
                    if (issue_idx == LAST_IDX) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // The last return is written on the edge that leaves DRAIN,
                // so vblank ending here still means an incomplete table.
                if (!in_vb) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end else begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (!in_vb) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, issue index, return tracking and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            issue_idx  <= '0;
            // Start as "already in vblank" so releasing reset in the middle
            // of a blanking interval does not look like a fresh entry.
            in_vb_q    <= 1'b1;
            rd_q       <= 1'b0;
            idx_q      <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every
            // flop samples pre-edge values regardless of statement order.
            state      <= state_next;
            in_vb_q    <= in_vb;
            rd_q       <= mem_rd;
            idx_q      <= issue_idx;
            frame_done <= finish;
            if (clr_idx) begin
                issue_idx <= '0;
            end else if (mem_rd) begin
                issue_idx <= issue_idx + 6'd1;
            end
            if (abort) begin
                overrun <= 1'b1;
            end
        end
    end

    // Shadow write: capture the RAM byte one cycle after its read strobe.
    always_ff @(posedge clk) begin
        // NOTE: the shadow array has no reset; its contents are undefined
        // until written, which keeps it mappable onto plain RAM.
        if (rd_q) begin
            shadow[wr_ptr] <= mem_data;
        end
    end

    // Registered display-side read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_rdata <= '0;
        end else begin
            buf_rdata <= shadow[rd_ptr];
        end
    end

endmodule

// File: tb/tb_pacman_obj_fetch.sv
// Testbench for pacman_obj_fetch: two instances (COUNT=16 and COUNT=4) share a
// behavioural RAM; expected reads and buffer contents are queued by the
// stimulus and compared by a separate negedge monitor.
module tb_pacman_obj_fetch;

    localparam logic [9:0] BASE = 10'h3F0;
    localparam int         CNT  = 16;
    localparam int         CNT2 = 4;
    localparam int         VBL  = 480;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ce = 1'b0;
    logic [9:0] svpos = '0;
    logic [9:0] mem_addr;
    logic       mem_rd;
    logic [7:0] mem_data = '0;
    logic [5:0] buf_raddr = '0;
    logic [7:0] buf_rdata;
    logic       frame_done;
    logic       busy;
    logic       overrun;

    logic       ce2 = 1'b1;
    logic [9:0] svpos2 = '0;
    logic [9:0] mem_addr2;
    logic       mem_rd2;
    logic [7:0] mem_data2 = '0;
    logic [5:0] buf_raddr2 = '0;
    logic [7:0] buf_rdata2;
    logic       frame_done2;
    logic       busy2;
    logic       overrun2;

    logic [7:0] ram [1024];
    logic [7:0] vis [64];
    bit         vis_ok [64];
    logic [7:0] tab_a [CNT2];
    logic [7:0] tab_b [CNT2];

    logic [9:0] exp_addr_q [$];
    logic [7:0] exp_buf_q [$];
    logic [7:0] exp_buf2_q [$];

    logic rd_req = 1'b0, rd_req_d = 1'b0;
    logic rd_req2 = 1'b0, rd_req2_d = 1'b0;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int rd_cnt = 0, done_cnt = 0, done_cyc = 0;
    int rd_cnt2 = 0, done_cnt2 = 0, done_cyc2 = 0;

    pacman_obj_fetch u_dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .svpos(svpos),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
        .buf_raddr(buf_raddr), .buf_rdata(buf_rdata),
        .frame_done(frame_done), .busy(busy), .overrun(overrun)
    );

    pacman_obj_fetch #(.COUNT(CNT2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .ce(ce2), .svpos(svpos2),
        .mem_addr(mem_addr2), .mem_rd(mem_rd2), .mem_data(mem_data2),
        .buf_raddr(buf_raddr2), .buf_rdata(buf_rdata2),
        .frame_done(frame_done2), .busy(busy2), .overrun(overrun2)
    );

    always #5 clk = ~clk;

    // Cycle counter, buffer-request delay and 1-cycle-latency RAM model.
    // Idle cycles return garbage so a wrong sampling cycle is visible.
    always @(posedge clk) begin
        cyc++;
        rd_req_d  <= rd_req;
        rd_req2_d <= rd_req2;
        mem_data  <= mem_rd  ? ram[mem_addr]  : 8'($urandom);
        mem_data2 <= mem_rd2 ? ram[mem_addr2] : 8'($urandom);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: pops and compares whenever a DUT presents a read or data.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_rd) begin
                rd_cnt++;
                check("rd_with_ce_low", 32'(ce), 32'd1);
                if (exp_addr_q.size() == 0) check("unexpected_rd", 32'(mem_addr), 32'hFFFF_FFFF);
                else check("rd_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
            end
            if (frame_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (rd_req_d) begin
                if (exp_buf_q.size() == 0) check("unexpected_buf_rd", 32'(buf_rdata), 32'hFFFF_FFFF);
                else check("buf_rdata", 32'(buf_rdata), 32'(exp_buf_q.pop_front()));
            end
            if (mem_rd2) rd_cnt2++;
            if (frame_done2) begin
                done_cnt2++;
                done_cyc2 = cyc;
            end
            if (rd_req2_d) begin
                if (exp_buf2_q.size() == 0) check("unexpected_buf2_rd", 32'(buf_rdata2), 32'hFFFF_FFFF);
                else check("buf2_rdata", 32'(buf_rdata2), 32'(exp_buf2_q.pop_front()));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [9:0] tab_addr(input int i);
        return BASE + 10'(i);
    endfunction

    task automatic randomize_table();
        for (int i = 0; i < CNT; i++) ram[tab_addr(i)] = 8'($urandom);
    endtask

    task automatic read_buf(input int idx);
        buf_raddr = 6'(idx);
        rd_req = 1'b1;
        exp_buf_q.push_back(vis[idx]);
        step();
        rd_req = 1'b0;
    endtask

    task automatic read_buf2(input int idx, input logic [7:0] exp);
        buf_raddr2 = 6'(idx);
        rd_req2 = 1'b1;
        exp_buf2_q.push_back(exp);
        step();
        rd_req2 = 1'b0;
    endtask

    task automatic read_all();
        for (int i = 0; i < 64; i++) if (vis_ok[i]) read_buf(i);
    endtask

    // One fetch frame on the COUNT=16 instance; ce_mode 0=on, 1=toggle, 2=random.
    task automatic do_frame(input int ce_mode, input bit chk_latency);
        int t0;
        int d0;
        int n;
        svpos = 10'(VBL - 1);
        step();
        step();
        for (int i = 0; i < CNT; i++) exp_addr_q.push_back(tab_addr(i));
        d0 = done_cnt;
        ce = (ce_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        svpos = 10'(VBL);
        t0 = cyc;
        n = 0;
        while (done_cnt == d0 && n < 300) begin
            step();
            if (ce_mode == 1) ce = ~ce;
            else if (ce_mode == 2) ce = 1'($urandom_range(0, 1));
            n++;
        end
        check("frame_done_seen", 32'(done_cnt - d0), 32'd1);
        if (chk_latency) check("done_latency", 32'(done_cyc - t0), 32'(CNT + 2));
        check("all_addr_issued", 32'(exp_addr_q.size()), 32'd0);
        step();
        check("busy_in_done", 32'(busy), 32'd0);
        for (int i = 0; i < CNT; i++) begin
            vis[i] = ram[tab_addr(i)];
            vis_ok[i] = 1'b1;
        end
    endtask

    task automatic leave_vblank();
        svpos = 10'd0;
        ce = 1'($urandom_range(0, 1));
        step();
        step();
    endtask

    initial begin
        int d0;
        int r0;
        int t0;
        int n;
        for (int i = 0; i < 1024; i++) ram[i] = 8'($urandom);
        for (int i = 0; i < 64; i++) vis_ok[i] = 1'b0;
        step();
        step();
        check("rst_mem_rd", 32'(mem_rd), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_buf_rdata", 32'(buf_rdata), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        step();

        // Continuous grant, known table i+0x20.
        for (int i = 0; i < CNT; i++) ram[tab_addr(i)] = 8'(i + 32'h20);
        do_frame(0, 1'b1);
        leave_vblank();
        read_buf(5);
        read_all();

        // Toggling grant, same table: same shadow contents expected.
        do_frame(1, 1'b0);
        leave_vblank();
        read_all();
        check("no_overrun_yet", 32'(overrun), 32'd0);

        // Grant never given during vblank: overrun, no frame_done, old data kept.
        randomize_table();
        svpos = 10'(VBL - 1);
        ce = 1'b0;
        step();
        d0 = done_cnt;
        r0 = rd_cnt;
        svpos = 10'(VBL);
        for (int k = 0; k < 40; k++) step();
        check("busy_while_starved", 32'(busy), 32'd1);
        svpos = 10'd0;
        step();
        step();
        check("overrun_set", 32'(overrun), 32'd1);
        check("no_done_on_abort", 32'(done_cnt - d0), 32'd0);
        check("no_rd_on_abort", 32'(rd_cnt - r0), 32'd0);
        check("idle_after_abort", 32'(busy), 32'd0);
        read_all();

        // Holding inside vblank after DONE must not refetch.
        randomize_table();
        do_frame(2, 1'b0);
        svpos = 10'd500;
        d0 = done_cnt;
        r0 = rd_cnt;
        for (int k = 0; k < 1000; k++) begin
            ce = 1'($urandom_range(0, 1));
            step();
        end
        check("no_refetch_rd", 32'(rd_cnt - r0), 32'd0);
        check("no_refetch_done", 32'(done_cnt - d0), 32'd0);
        leave_vblank();
        read_all();
        randomize_table();
        do_frame(0, 1'b1);
        leave_vblank();
        read_all();

        // Reset in the middle of a fetch.
        randomize_table();
        svpos = 10'(VBL - 1);
        step();
        for (int i = 0; i < CNT; i++) exp_addr_q.push_back(tab_addr(i));
        ce = 1'b1;
        svpos = 10'(VBL);
        for (int k = 0; k < 6; k++) step();
        check("busy_before_rst", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_mem_rd", 32'(mem_rd), 32'd0);
        check("midrst_mem_addr", 32'(mem_addr), 32'd0);
        check("midrst_buf_rdata", 32'(buf_rdata), 32'd0);
        check("midrst_frame_done", 32'(frame_done), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_overrun", 32'(overrun), 32'd0);
        exp_addr_q.delete();
        for (int i = 0; i < 64; i++) vis_ok[i] = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        r0 = rd_cnt;
        d0 = done_cnt;
        for (int k = 0; k < 50; k++) step();
        check("no_fetch_after_rst", 32'(rd_cnt - r0), 32'd0);
        check("no_done_after_rst", 32'(done_cnt - d0), 32'd0);
        check("idle_after_rst", 32'(busy), 32'd0);
        leave_vblank();
        randomize_table();
        do_frame(0, 1'b1);
        leave_vblank();
        read_all();
        check("overrun_clear_after_rst", 32'(overrun), 32'd0);

        // COUNT=4 instance: one good frame, then abort on the last-return cycle.
        for (int i = 0; i < CNT2; i++) begin
            tab_a[i] = 8'($urandom);
            tab_b[i] = ~tab_a[i];
            ram[tab_addr(i)] = tab_a[i];
        end
        svpos2 = 10'(VBL - 1);
        step();
        step();
        d0 = done_cnt2;
        r0 = rd_cnt2;
        svpos2 = 10'(VBL);
        t0 = cyc;
        n = 0;
        while (done_cnt2 == d0 && n < 100) begin
            step();
            n++;
        end
        check("c4_done_seen", 32'(done_cnt2 - d0), 32'd1);
        check("c4_done_latency", 32'(done_cyc2 - t0), 32'(CNT2 + 2));
        check("c4_reads", 32'(rd_cnt2 - r0), 32'(CNT2));
        svpos2 = 10'd0;
        step();
        step();
        for (int i = 0; i < CNT2; i++) read_buf2(i, tab_a[i]);

        for (int i = 0; i < CNT2; i++) ram[tab_addr(i)] = tab_b[i];
        svpos2 = 10'(VBL - 1);
        step();
        step();
        d0 = done_cnt2;
        r0 = rd_cnt2;
        svpos2 = 10'(VBL);
        for (int k = 0; k < 5; k++) step();
        check("c4_busy_in_drain", 32'(busy2), 32'd1);
        check("c4_overrun_before", 32'(overrun2), 32'd0);
        svpos2 = 10'd0;
        step();
        step();
        check("c4_overrun_set", 32'(overrun2), 32'd1);
        check("c4_no_done", 32'(done_cnt2 - d0), 32'd0);
        check("c4_abort_reads", 32'(rd_cnt2 - r0), 32'(CNT2));
        check("c4_idle", 32'(busy2), 32'd0);
`ifdef OBJFETCH_DBUF_EN
        for (int i = 0; i < CNT2; i++) read_buf2(i, tab_a[i]);
`else
        for (int i = 0; i < CNT2; i++) read_buf2(i, tab_b[i]);
`endif
        step();
        check("buf_queue_empty", 32'(exp_buf_q.size() + exp_buf2_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
